// File: rtl/alu_issue_ctrl.sv
// Issue/control FSM for the 8-bit ALU. It accepts one instruction at a time, reads its
// operands, drives the ALU, then writes the result (and optionally the carry) back to the register file.
module alu_issue_ctrl #(
  parameter int REG_W    = 8,
  parameter int OP_W     = 4,
  parameter int ADDR_W   = 3,
  parameter int CAR_REG  = 7,
  parameter int CARRY_WB = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [8:0]        instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic [ADDR_W-1:0] rf_ra_addr,
  output logic [ADDR_W-1:0] rf_rb_addr,
  input  logic [REG_W-1:0]  rf_ra_data,
  input  logic [REG_W-1:0]  rf_rb_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_wa,
  output logic [REG_W-1:0]  rf_wd,
  output logic [OP_W-1:0]   alu_op,
  output logic [REG_W-1:0]  alu_ra,
  output logic [REG_W-1:0]  alu_rb,
  input  logic [REG_W-1:0]  alu_res,
  input  logic [REG_W-1:0]  alu_car,
  input  logic              alu_zero,
  input  logic              alu_jump,
  output logic              zero_flag,
  output logic              branch_taken,
  output logic              illegal,
  output logic              busy,
  output logic              halted
);

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_EXEC, S_WB, S_WB_CAR, S_HALT
  } state_t;

  localparam logic [OP_W-1:0]   OP_ADD  = OP_W'(4);
  localparam logic [OP_W-1:0]   OP_SUB  = OP_W'(5);
  localparam logic [OP_W-1:0]   OP_MOV  = OP_W'(6);
  localparam logic [OP_W-1:0]   OP_BEQ  = OP_W'(7);
  localparam logic [OP_W-1:0]   OP_SRL  = OP_W'(8);
  localparam logic [OP_W-1:0]   OP_SRA  = OP_W'(9);
  localparam logic [OP_W-1:0]   OP_SLL  = OP_W'(10);
  localparam logic [OP_W-1:0]   OP_HALT = OP_W'(11);
  localparam logic [ADDR_W-1:0] CAR_ADDR = ADDR_W'(CAR_REG);

  state_t            state_q, state_d;
  logic [8:0]        instr_q, instr_d;
  logic [OP_W-1:0]   alu_op_q, alu_op_d;
  logic [REG_W-1:0]  alu_ra_q, alu_ra_d;
  logic [REG_W-1:0]  alu_rb_q, alu_rb_d;
  logic [REG_W-1:0]  car_q, car_d;
  logic              zero_s_q, zero_s_d;
  logic              zero_flag_q, zero_flag_d;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_wa_q, rf_wa_d;
  logic [REG_W-1:0]  rf_wd_q, rf_wd_d;
  logic              branch_q, branch_d;
  logic              illegal_q, illegal_d;

  logic [OP_W-1:0]   opc;
  logic [ADDR_W-1:0] ra_idx;
  logic [ADDR_W-1:0] rb_idx;
  logic              carry_op;

  assign opc      = OP_W'(instr_q[8:5]);
  assign ra_idx   = ADDR_W'(instr_q[4:2]);
  assign rb_idx   = ADDR_W'(instr_q[1:0]);
  assign carry_op = (CARRY_WB != 0) && (opc inside {OP_ADD, OP_SUB, OP_SRL, OP_SRA, OP_SLL});

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    alu_op_d    = alu_op_q;
    alu_ra_d    = alu_ra_q;
    alu_rb_d    = alu_rb_q;
    car_d       = car_q;
    zero_s_d    = zero_s_q;
    zero_flag_d = zero_flag_q;
    rf_we_d     = 1'b0;
    rf_wa_d     = rf_wa_q;
    rf_wd_d     = rf_wd_q;
    branch_d    = 1'b0;
    illegal_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          instr_d = instr;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        // HALT must be tested before the illegal range since 11 lies above the last ALU op.
        if (opc == OP_HALT) begin
          state_d = S_HALT;
        end else if (opc > OP_SLL) begin
          illegal_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          alu_op_d = opc;
          alu_ra_d = (opc == OP_MOV) ? rf_rb_data : rf_ra_data;
          alu_rb_d = rf_rb_data;
          state_d  = S_EXEC;
        end
      end
      S_EXEC: begin
        car_d    = alu_car;
        zero_s_d = alu_zero;
        if (opc == OP_BEQ) begin
          branch_d = alu_jump;
          state_d  = S_IDLE;
        end else begin
          rf_we_d = 1'b1;
          rf_wa_d = ra_idx;
          rf_wd_d = alu_res;
          state_d = S_WB;
        end
      end
      S_WB: begin
        zero_flag_d = zero_s_q;
        if (carry_op) begin
          rf_we_d = 1'b1;
          rf_wa_d = CAR_ADDR;
          rf_wd_d = car_q;
          state_d = S_WB_CAR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WB_CAR: state_d = S_IDLE;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      instr_q     <= '0;
      alu_op_q    <= '0;
      alu_ra_q    <= '0;
      alu_rb_q    <= '0;
      car_q       <= '0;
      zero_s_q    <= 1'b0;
      zero_flag_q <= 1'b0;
      rf_we_q     <= 1'b0;
      rf_wa_q     <= '0;
      rf_wd_q     <= '0;
      branch_q    <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      alu_op_q    <= alu_op_d;
      alu_ra_q    <= alu_ra_d;
      alu_rb_q    <= alu_rb_d;
      car_q       <= car_d;
      zero_s_q    <= zero_s_d;
      zero_flag_q <= zero_flag_d;
      rf_we_q     <= rf_we_d;
      rf_wa_q     <= rf_wa_d;
      rf_wd_q     <= rf_wd_d;
      branch_q    <= branch_d;
      illegal_q   <= illegal_d;
    end
  end

  assign instr_ready  = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halted       = (state_q == S_HALT);
  assign rf_ra_addr   = ra_idx;
  assign rf_rb_addr   = rb_idx;
  assign rf_we        = rf_we_q;
  assign rf_wa        = rf_wa_q;
  assign rf_wd        = rf_wd_q;
  assign alu_op       = alu_op_q;
  assign alu_ra       = alu_ra_q;
  assign alu_rb       = alu_rb_q;
  assign zero_flag    = zero_flag_q;
  assign branch_taken = branch_q;
  assign illegal      = illegal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: register file and ALU models around the controller, with a
// write-back scoreboard and directed timing checks.
module tb_alu_issue_ctrl;

  logic       clk, reset;
  logic [8:0] instr;
  logic       instr_valid, instr_ready;
  logic [2:0] rf_ra_addr, rf_rb_addr, rf_wa;
  logic [7:0] rf_ra_data, rf_rb_data, rf_wd;
  logic       rf_we;
  logic [3:0] alu_op;
  logic [7:0] alu_ra, alu_rb, alu_res, alu_car;
  logic       alu_zero, alu_jump;
  logic       zero_flag, branch_taken, illegal, busy, halted;

  int checks = 0;
  int errors = 0;

  typedef struct packed { logic [2:0] addr; logic [7:0] data; } wr_t;
  wr_t sb[$];

  logic [7:0] rf [8];
  logic       tb_we;
  logic [2:0] tb_wa;
  logic [7:0] tb_wd;

  alu_issue_ctrl dut (
    .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .rf_ra_addr(rf_ra_addr), .rf_rb_addr(rf_rb_addr),
    .rf_ra_data(rf_ra_data), .rf_rb_data(rf_rb_data), .rf_we(rf_we), .rf_wa(rf_wa),
    .rf_wd(rf_wd), .alu_op(alu_op), .alu_ra(alu_ra), .alu_rb(alu_rb),
    .alu_res(alu_res), .alu_car(alu_car), .alu_zero(alu_zero), .alu_jump(alu_jump),
    .zero_flag(zero_flag), .branch_taken(branch_taken), .illegal(illegal),
    .busy(busy), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rf_we) rf[rf_wa] <= rf_wd;
    else if (tb_we) rf[tb_wa] <= tb_wd;
  end
  assign rf_ra_data = rf[rf_ra_addr];
  assign rf_rb_data = rf[rf_rb_addr];

  // Reference ALU: carry is the 9th bit for ADD, borrow for SUB, zero otherwise.
  logic [8:0] wide;
  always_comb begin
    wide     = 9'd0;
    alu_jump = 1'b0;
    case (alu_op)
      4'd0:  wide = {1'b0, alu_ra & alu_rb};
      4'd1:  wide = {8'd0, $signed(alu_ra) < $signed(alu_rb)};
      4'd2:  wide = {1'b0, alu_ra | alu_rb};
      4'd3:  wide = {1'b0, ~alu_ra};
      4'd4:  wide = {1'b0, alu_ra} + {1'b0, alu_rb};
      4'd5:  wide = {1'b0, alu_ra} - {1'b0, alu_rb};
      4'd6:  wide = {1'b0, alu_ra};
      4'd7:  begin wide = {1'b0, alu_ra - alu_rb}; alu_jump = (alu_ra == alu_rb); end
      4'd8:  wide = {1'b0, alu_ra >> alu_rb[2:0]};
      4'd9:  wide = {1'b0, 8'($signed(alu_ra) >>> alu_rb[2:0])};
      4'd10: wide = {1'b0, alu_ra << alu_rb[2:0]};
      default: wide = 9'd0;
    endcase
  end
  assign alu_res  = wide[7:0];
  assign alu_car  = {7'd0, wide[8]};
  assign alu_zero = (wide[7:0] == 8'd0);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rf_we) begin
      if (sb.size() == 0) begin
        chk("unexpected_write", {21'd0, rf_wa, rf_wd}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = sb.pop_front();
        chk("wb_addr", {29'd0, rf_wa}, {29'd0, e.addr});
        chk("wb_data", {24'd0, rf_wd}, {24'd0, e.data});
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    tb_we = 1'b1; tb_wa = a; tb_wd = d;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  task automatic push(input logic [2:0] a, input logic [7:0] d);
    wr_t e;
    e.addr = a; e.data = d;
    sb.push_back(e);
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!instr_ready && n < 50) begin @(negedge clk); n++; end
    chk(tag, {31'd0, instr_ready}, 32'd1);
  endtask

  // Returns at the negedge of the DECODE cycle (cycle 1 after acceptance).
  task automatic issue(input logic [3:0] op, input logic [2:0] ra, input logic [1:0] rb);
    wait_ready("ready_wait");
    instr = {op, ra, rb}; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; instr = '0; instr_valid = 1'b0;
    tb_we = 1'b0; tb_wa = '0; tb_wd = '0;
    cyc(2);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_we", {31'd0, rf_we}, 32'd0);
    chk("rst_zero", {31'd0, zero_flag}, 32'd0);
    chk("rst_aluop", {28'd0, alu_op}, 32'd0);
    chk("rst_wd", {24'd0, rf_wd}, 32'd0);
    chk("rst_ready", {31'd0, instr_ready}, 32'd1);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) wr(3'(i), 8'd0);

    // ADD 200+100 -> r1=44, carry r7=1, ready again in cycle 5
    wr(3'd1, 8'd200); wr(3'd2, 8'd100);
    push(3'd1, 8'd44); push(3'd7, 8'd1);
    issue(4'd4, 3'd1, 2'd2);
    chk("add_busy", {31'd0, busy}, 32'd1);
    chk("add_ready_c1", {31'd0, instr_ready}, 32'd0);
    cyc(1);
    chk("add_aluop", {28'd0, alu_op}, 32'd4);
    chk("add_alura", {24'd0, alu_ra}, 32'd200);
    chk("add_alurb", {24'd0, alu_rb}, 32'd100);
    cyc(2);
    chk("add_ready_c4", {31'd0, instr_ready}, 32'd0);
    cyc(1);
    chk("add_ready_c5", {31'd0, instr_ready}, 32'd1);
    chk("add_zero", {31'd0, zero_flag}, 32'd0);
    chk("add_r1", {24'd0, rf[1]}, 32'd44);
    chk("add_r7", {24'd0, rf[7]}, 32'd1);

    // SUB 5-5 -> r3=0, zero_flag=1, r7=0
    wr(3'd3, 8'd5); wr(3'd1, 8'd5);
    push(3'd3, 8'd0); push(3'd7, 8'd0);
    issue(4'd5, 3'd3, 2'd1);
    cyc(4);
    chk("sub_ready_c5", {31'd0, instr_ready}, 32'd1);
    chk("sub_zero", {31'd0, zero_flag}, 32'd1);
    chk("sub_r3", {24'd0, rf[3]}, 32'd0);

    // BEQ on equal registers: one-cycle branch pulse, no write
    issue(4'd7, 3'd1, 2'd1);
    cyc(1);
    chk("beq_br_c2", {31'd0, branch_taken}, 32'd0);
    cyc(1);
    chk("beq_br_c3", {31'd0, branch_taken}, 32'd1);
    chk("beq_ready_c3", {31'd0, instr_ready}, 32'd1);
    cyc(1);
    chk("beq_br_c4", {31'd0, branch_taken}, 32'd0);

    // BEQ on unequal registers: no pulse, idle in cycle 3
    wr(3'd3, 8'd5); wr(3'd1, 8'd6);
    issue(4'd7, 3'd3, 2'd1);
    cyc(2);
    chk("bne_br_c3", {31'd0, branch_taken}, 32'd0);
    chk("bne_ready_c3", {31'd0, instr_ready}, 32'd1);
    cyc(1);
    chk("bne_br_c4", {31'd0, branch_taken}, 32'd0);
    chk("beq_keeps_zero", {31'd0, zero_flag}, 32'd1);

    // Illegal opcode 13
    issue(4'd13, 3'd2, 2'd1);
    chk("ill_c1", {31'd0, illegal}, 32'd0);
    cyc(1);
    chk("ill_c2", {31'd0, illegal}, 32'd1);
    chk("ill_ready", {31'd0, instr_ready}, 32'd1);
    cyc(1);
    chk("ill_c3", {31'd0, illegal}, 32'd0);

    // MOV r4 <- r2, no carry write, ready in cycle 4
    push(3'd4, 8'd100);
    issue(4'd6, 3'd4, 2'd2);
    cyc(3);
    chk("mov_ready_c4", {31'd0, instr_ready}, 32'd1);
    chk("mov_r4", {24'd0, rf[4]}, 32'd100);
    chk("mov_zero", {31'd0, zero_flag}, 32'd0);

    // SLL 0x81 << 4 -> 0x10, shift ops also write back carry
    wr(3'd5, 8'h81);
    push(3'd5, 8'h10); push(3'd7, 8'd0);
    issue(4'd10, 3'd5, 2'd2);
    cyc(4);
    chk("sll_ready_c5", {31'd0, instr_ready}, 32'd1);

    // Reset in the middle of an ADD's EXEC cycle discards it
    wr(3'd1, 8'd200);
    issue(4'd4, 3'd1, 2'd2);
    cyc(1);
    reset = 1'b1;
    #1;
    chk("mid_rst_aluop", {28'd0, alu_op}, 32'd0);
    chk("mid_rst_alura", {24'd0, alu_ra}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_we", {31'd0, rf_we}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    push(3'd1, 8'h40);
    issue(4'd0, 3'd1, 2'd2);
    wait_ready("post_rst_ready");
    chk("post_rst_r1", {24'd0, rf[1]}, 32'h40);

    // Back-to-back ANDs with instr_valid held high
    wr(3'd4, 8'hF0); wr(3'd1, 8'h3C); wr(3'd5, 8'hAA);
    wr(3'd2, 8'h0F); wr(3'd6, 8'hFF); wr(3'd3, 8'h55);
    push(3'd4, 8'h30); push(3'd5, 8'h0A); push(3'd6, 8'h55);
    instr_valid = 1'b1;
    instr = {4'd0, 3'd4, 2'd1};
    wait_ready("b2b_0"); @(negedge clk);
    instr = {4'd0, 3'd5, 2'd2};
    wait_ready("b2b_1"); @(negedge clk);
    instr = {4'd0, 3'd6, 2'd3};
    wait_ready("b2b_2"); @(negedge clk);
    instr_valid = 1'b0;
    begin
      int n = 0;
      while (sb.size() != 0 && n < 50) begin @(negedge clk); n++; end
    end
    chk("b2b_drained", sb.size(), 32'd0);
    wait_ready("b2b_ready");

    // HALT is sticky and ignores further instructions
    issue(4'd11, 3'd0, 2'd0);
    instr = {4'd0, 3'd1, 2'd1}; instr_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      chk("halt_ready", {31'd0, instr_ready}, 32'd0);
      chk("halt_halted", {30'd0, halted, busy}, 32'd2);
    end
    instr_valid = 1'b0;
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    cyc(1);
    chk("unhalt_ready", {31'd0, instr_ready}, 32'd1);
    chk("unhalt_halted", {31'd0, halted}, 32'd0);
    chk("sb_empty", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
